// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state type, default divisor and divisor normalisation for scan_tick_gen
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } scan_tick_state_t;

  localparam logic [15:0] SCAN_DEFAULT_DIV = 16'd1000;

  // Divisor 0 would never strobe, so it is treated as 1 (strobe every cycle).
  function automatic logic [31:0] norm_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/scan_tick_gen_if.sv
// rtl/scan_tick_gen_if.sv - divisor valid/ready handshake bundle
interface scan_tick_gen_if #(
  parameter int DIV_WIDTH = 16
) ();

  logic [DIV_WIDTH-1:0] div_in;
  logic                 div_valid;
  logic                 div_ready;

  modport master (output div_in, output div_valid, input div_ready);
  modport slave  (input div_in, input div_valid, output div_ready);

endinterface

// File: rtl/scan_tick_gen_tick_counter.sv
// rtl/scan_tick_gen_tick_counter.sv - divide counter with sync clear and registered one-cycle strobe
module tick_counter #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 cnt_en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 ena_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ena_q, ena_d;
  logic                 hit;

  assign hit   = (cnt_q == (div_i - DIV_WIDTH'(1)));
  assign ena_o = ena_q;

  always_comb begin
    cnt_d = cnt_q;
    ena_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_en_i) begin
      if (hit) begin
        cnt_d = '0;
        ena_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ena_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ena_q <= ena_d;
    end
  end

endmodule

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - programmable scan strobe generator; new divisors apply only at sweep boundaries
module scan_tick_gen
  import scan_pkg::*;
#(
  parameter int                   DIV_WIDTH   = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(SCAN_DEFAULT_DIV)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 sweep_done,
  scan_tick_gen_if.slave       div_bus,
  output logic                 ena_o,
  output logic [DIV_WIDTH-1:0] active_div,
  output logic                 pending
);

  scan_tick_state_t     state_q, state_d;
  logic [DIV_WIDTH-1:0] active_div_q, active_div_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic [DIV_WIDTH-1:0] div_norm;
  logic                 xfer;
  logic                 clr;
  logic                 cnt_en;

  assign div_norm          = DIV_WIDTH'(norm_div(32'(div_bus.div_in)));
  assign div_bus.div_ready = (state_q != PEND);
  assign xfer              = div_bus.div_valid && div_bus.div_ready;
  assign active_div        = active_div_q;
  assign pending           = (state_q == PEND);

  always_comb begin
    state_d      = state_q;
    active_div_d = active_div_q;
    pend_div_d   = pend_div_q;
    clr          = 1'b0;
    cnt_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (xfer) active_div_d = div_norm;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          // Stopping with a fresh divisor: there is no sweep to protect, apply it now.
          clr     = 1'b1;
          state_d = IDLE;
          if (xfer) active_div_d = div_norm;
        end else begin
          cnt_en = 1'b1;
          if (xfer) begin
            pend_div_d = div_norm;
            state_d    = PEND;
          end
        end
      end
      PEND: begin
        // run=0 wins over sweep_done, but both apply the waiting divisor.
        if (!run || sweep_done) begin
          clr          = 1'b1;
          active_div_d = pend_div_q;
          state_d      = run ? RUN : IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        clr     = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      active_div_q <= DEFAULT_DIV;
      pend_div_q   <= '0;
    end else begin
      state_q      <= state_d;
      active_div_q <= active_div_d;
      pend_div_q   <= pend_div_d;
    end
  end

  tick_counter #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .cnt_en_i(cnt_en),
    .div_i   (active_div_q),
    .ena_o   (ena_o)
  );

endmodule

// File: tb/tb_scan_tick_gen.sv
// tb/tb_scan_tick_gen.sv - directed-vector scoreboard bench for scan_tick_gen
module tb_scan_tick_gen;

  typedef struct {
    string       tag;
    logic        ena;
    logic [15:0] div;
    logic        pend;
    logic        rdy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        run;
  logic        sweep_done;
  logic        ena_o;
  logic [15:0] active_div;
  logic        pending;

  int vectors;
  int miscompares;
  exp_t exp_q[$];
  exp_t e;

  scan_tick_gen_if #(.DIV_WIDTH(16)) bus ();

  scan_tick_gen #(
    .DIV_WIDTH  (16),
    .DEFAULT_DIV(16'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .sweep_done(sweep_done),
    .div_bus   (bus.slave),
    .ena_o     (ena_o),
    .active_div(active_div),
    .pending   (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one edge's inputs and queue the outputs expected just after that edge.
  task automatic step(input string tag, input logic r, input logic rn, input logic sw,
                      input logic v, input logic [15:0] d,
                      input logic e_ena, input logic [15:0] e_div, input logic e_pend,
                      input logic e_rdy);
    exp_t x;
    @(negedge clk);
    rst           = r;
    run           = rn;
    sweep_done    = sw;
    bus.div_valid = v;
    bus.div_in    = d;
    x.tag  = tag;
    x.ena  = e_ena;
    x.div  = e_div;
    x.pend = e_pend;
    x.rdy  = e_rdy;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (ena_o !== e.ena || active_div !== e.div || pending !== e.pend ||
          bus.div_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL %s: got ena=%0b div=%0d pend=%0b rdy=%0b, want ena=%0b div=%0d pend=%0b rdy=%0b",
                 e.tag, ena_o, active_div, pending, bus.div_ready,
                 e.ena, e.div, e.pend, e.rdy);
      end
    end
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    run           = 1'b0;
    sweep_done    = 1'b0;
    bus.div_valid = 1'b0;
    bus.div_in    = 16'd0;

    step("reset", 1, 0, 0, 0, 0, 0, 4, 0, 1);
    step("reset", 1, 0, 0, 0, 0, 0, 4, 0, 1);

    // D=4 from default; a stray sweep_done in RUN is ignored
    step("start_d4", 0, 1, 0, 0, 0, 0, 4, 0, 1);
    for (int i = 1; i <= 12; i++)
      step("run_d4", 0, 1, (i == 6), 0, 0, (i % 4 == 0), 4, 0, 1);

    // divisor 6 queued; an offer while pending must be refused
    step("xfer6", 0, 1, 0, 1, 16'd6, 0, 4, 1, 0);
    for (int j = 14; j <= 21; j++)
      step("pend_d4", 0, 1, 0, (j == 15), 16'd9, (j % 4 == 0), 4, 1, 0);
    step("apply6", 0, 1, 1, 0, 0, 0, 6, 0, 1);
    for (int i = 1; i <= 12; i++)
      step("run_d6", 0, 1, 0, 0, 0, (i % 6 == 0), 6, 0, 1);

    // transfer coinciding with sweep_done stays pending until the next sweep_done
    step("xfer_sweep", 0, 1, 1, 1, 16'd3, 0, 6, 1, 0);
    for (int i = 2; i <= 7; i++)
      step("held", 0, 1, 0, 0, 0, (i == 6), 6, 1, 0);
    step("apply3", 0, 1, 1, 0, 0, 0, 3, 0, 1);
    for (int i = 1; i <= 6; i++)
      step("run_d3", 0, 1, 0, 0, 0, (i % 3 == 0), 3, 0, 1);

    // pending 0 (->1), then run=0 and sweep_done together
    step("xfer0", 0, 1, 0, 1, 16'd0, 0, 3, 1, 0);
    step("pend_d3", 0, 1, 0, 0, 0, 0, 3, 1, 0);
    step("pend_d3", 0, 1, 0, 0, 0, 1, 3, 1, 0);
    step("stop_sweep", 0, 0, 1, 0, 0, 0, 1, 0, 1);
    step("idle", 0, 0, 0, 0, 0, 0, 1, 0, 1);

    // IDLE transfers land directly; D=1 strobes every cycle
    step("idle_xfer5", 0, 0, 0, 1, 16'd5, 0, 5, 0, 1);
    step("idle_xfer0", 0, 0, 0, 1, 16'd0, 0, 1, 0, 1);
    step("start_d1", 0, 1, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 5; i++)
      step("run_d1", 0, 1, 0, 0, 0, 1, 1, 0, 1);

    // reset while pending discards the waiting divisor
    step("xfer7", 0, 1, 0, 1, 16'd7, 1, 1, 1, 0);
    step("rst_pend", 1, 1, 0, 0, 0, 0, 4, 0, 1);
    step("post_rst", 0, 0, 0, 0, 0, 0, 4, 0, 1);
    step("start_d4b", 0, 1, 0, 0, 0, 0, 4, 0, 1);
    for (int i = 1; i <= 7; i++)
      step("run_d4b", 0, 1, 0, 0, 0, (i == 4), 4, 0, 1);
    // strobe was due on this edge, but run=0 suppresses it
    step("stop_due", 0, 0, 0, 0, 0, 0, 4, 0, 1);
    step("idle_end", 0, 0, 0, 0, 0, 0, 4, 0, 1);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_tick_gen.md
# scan_tick_gen

Programmable rate generator that produces the single-cycle shift-enable strobe for the bouncing one-hot LED scanner. It sits directly upstream of the scanner and drives its `ena` input. It accepts new divisor values over a valid/ready handshake. While scanning, a new divisor takes effect only at a sweep boundary, signalled by the scanner's end-of-sweep pulse, so speed never changes mid-sweep.

## Interface
- `DIV_WIDTH`, 16: width of divisor and internal counter.
- `DEFAULT_DIV`, 16'd1000: divisor loaded at reset; must be ≥ 1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `run`  in  1  level; 1 = generate strobes, 0 = halt.
- `div_in`  in  DIV_WIDTH  requested divisor; value 0 is treated as 1.
- `div_valid`  in  1  `div_in` is offered.
- `div_ready`  out  1  block can accept a divisor this cycle.
- `sweep_done`  in  1  end-of-sweep pulse from the scanner, sampled on rising `clk`.
- `ena_o`  out  1  registered one-cycle shift strobe to the scanner.
- `active_div`  out  DIV_WIDTH  divisor currently in use, after 0→1 mapping.
- `pending`  out  1  an accepted divisor is waiting for a sweep boundary.

## Operation
- Reset, while `rst`=1 at an edge: state IDLE, `cnt`=0, `ena_o`=0, `active_div`=DEFAULT_DIV, pending register=0, `pending`=0, `div_ready`=1.
- A transfer occurs on an edge where `div_valid && div_ready`. The stored value is `div_in`==0 ? 1 : `div_in`.
- `div_ready` = (state != PEND). Combinational from state only; it does not depend on `div_valid`.
- State IDLE:
  - `cnt` held at 0, `ena_o`=0.
  - A transfer writes `active_div` directly.
  - `run`=1 → RUN, with `cnt`=0.
- State RUN:
  - Each edge: if `cnt` == `active_div`−1 then `cnt`←0 and `ena_o`←1; else `cnt`←`cnt`+1 and `ena_o`←0.
  - A transfer writes the pending register → PEND.
- State PEND:
  - Counting continues as in RUN with the old `active_div`.
  - On an edge with `sweep_done`=1: `active_div`←pending register, `cnt`←0, `ena_o`←0 → RUN.
- `run`=0 at an edge, from RUN or PEND → IDLE:
  - `cnt`←0, `ena_o`←0.
  - In PEND, the pending value is applied to `active_div` on that same edge.
  - `run`=0 has priority over `sweep_done`.
- `sweep_done` is ignored in IDLE and RUN.
- A transfer and `sweep_done` on the same edge in RUN: the value goes to pending. It is applied only on a later `sweep_done`.
- `cnt` is DIV_WIDTH wide. It never exceeds `active_div`−1, so no wrap-around beyond the compare.
- `pending` = (state == PEND).

## Timing
- With `run` sampled 1 at edge k (IDLE→RUN), the first `ena_o` is high in the cycle after edge k+D, where D=`active_div`. Subsequent strobes follow every D cycles.
- D=1: `ena_o` is high continuously from the cycle after edge k+1.
- `run` deasserted at edge m: `ena_o` is 0 from the cycle after edge m, even if a strobe was due.
- New divisor: the first strobe at the new rate comes D_new edges after the applying `sweep_done` edge.
- `rst` mid-operation discards any pending divisor and restores DEFAULT_DIV on that edge.
- Handshake latency: `div_ready` falls in the cycle after a transfer in RUN. It rises in the cycle after the applying edge.

## Structure
- Package `scan_pkg` holds:
  - the state typedef `scan_tick_state_t` {IDLE, RUN, PEND};
  - the constant `SCAN_DEFAULT_DIV`;
  - the helper function `norm_div` implementing the 0→1 mapping.
- One sub-module is natural: `tick_counter`. It contains the DIV_WIDTH counter with clear, compare against `active_div`−1, and the registered strobe. The FSM and handshake stay in `scan_tick_gen`.

## Test plan
- Reset then `run`=1 with DEFAULT_DIV overridden to 4 → `ena_o` pulses exactly at edges k+4, k+8, k+12; `active_div`=4.
- In IDLE, transfer `div_in`=0, then `run`=1 → `active_div`=1 and `ena_o` high every cycle from edge k+1.
- In RUN with D=4, transfer 6 → `pending`=1 and `div_ready`=0. Strobes keep 4-cycle spacing until `sweep_done`; after it, spacing is 6 and `pending`=0.
- In RUN, a transfer and `sweep_done` on the same edge → value held pending. It is applied only at the next `sweep_done`.
- In PEND, `run`=0 and `sweep_done`=1 on the same edge → IDLE, `ena_o`=0 next cycle, `active_div`=pending value, `div_ready`=1.
- `rst`=1 asserted while in PEND mid-count → next cycle: IDLE, `cnt`=0, `ena_o`=0, `active_div`=DEFAULT_DIV, `pending`=0.
